// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// with registered quotient/remainder/div_zero and a one-cycle div_end pulse.
module divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  div_begin,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] div_op1,
  input  logic [DATA_WIDTH-1:0] div_op2,
  output logic                  busy,
  output logic                  div_end,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_zero
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   quot_q, quot_d;
  logic [DATA_WIDTH-1:0]   remo_q, remo_d;
  logic                    zero_out_q, zero_out_d;

  // Datapath operands; only meaningful while RUN, so they carry no reset.
  logic [DATA_WIDTH-1:0]   dvd_q, dvs_q, rem_q, op1_raw_q;
  logic                    s1_q, s2_q, zero_q;

  logic                    start;
  logic                    last_run;
  logic                    start_s1, start_s2;
  logic [DATA_WIDTH:0]     shifted, trial;
  logic [DATA_WIDTH-1:0]   rem_nxt, dvd_nxt;
  logic                    qbit;

  function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                   input logic                  n);
    return n ? (~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign start_s1 = div_signed & div_op1[DATA_WIDTH-1];
  assign start_s2 = div_signed & div_op2[DATA_WIDTH-1];

  // Control: state, counter and start acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (div_begin) begin
          state_d = RUN;
          cnt_d   = '0;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_run = (state_q == RUN) && (cnt_q == LAST);

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    shifted = {rem_q, dvd_q[DATA_WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[DATA_WIDTH];
    rem_nxt = qbit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    dvd_nxt = {dvd_q[DATA_WIDTH-2:0], qbit};
  end

  always_comb begin
    quot_d     = quot_q;
    remo_d     = remo_q;
    zero_out_d = zero_out_q;
    if (last_run) begin
      if (zero_q) begin
        quot_d     = '1;
        remo_d     = op1_raw_q;
        zero_out_d = 1'b1;
      end else begin
        quot_d     = neg_if(dvd_nxt, s1_q ^ s2_q);
        remo_d     = neg_if(rem_nxt, s1_q);
        zero_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      quot_q     <= '0;
      remo_q     <= '0;
      zero_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      remo_q     <= remo_d;
      zero_out_q <= zero_out_d;
    end
  end

  // Operand capture on start; the quotient bits shift into the dividend register.
  always_ff @(posedge clk) begin
    if (start) begin
      s1_q      <= start_s1;
      s2_q      <= start_s2;
      zero_q    <= (div_op2 == '0);
      op1_raw_q <= div_op1;
      dvd_q     <= neg_if(div_op1, start_s1);
      dvs_q     <= neg_if(div_op2, start_s2);
      rem_q     <= '0;
    end else if (state_q == RUN) begin
      dvd_q     <= dvd_nxt;
      rem_q     <= rem_nxt;
    end
  end

  assign busy      = (state_q == RUN);
  assign div_end   = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = zero_out_q;

endmodule
